// File: rtl/ql_membank_config_writer.sv
// ql_membank_config_writer: streams bitstream words into BL rows and
// pulses one WL per row to program the QL memory-bank fabric.
module ql_membank_config_writer #(
    parameter int BL_WIDTH  = 514,
    parameter int WL_WIDTH  = 407,
    parameter int DIN_WIDTH = 32,
    parameter int WL_PULSE  = 2
) (
    input  logic                 clk,
    input  logic                 global_resetn,
    input  logic                 start,
    input  logic                 din_valid,
    input  logic [DIN_WIDTH-1:0] din_data,
    output logic                 din_ready,
    output logic [BL_WIDTH-1:0]  bl_out,
    output logic [WL_WIDTH-1:0]  wl_out,
    output logic                 busy,
    output logic                 done
);

    localparam int WPR = (BL_WIDTH + DIN_WIDTH - 1) / DIN_WIDTH;
    localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RW  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int PW  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [WW-1:0] WORD_LAST  = WW'(WPR - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(WL_WIDTH - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(WL_PULSE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] word_q, word_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          done_d;
    logic          accept;

    // din_ready is high exactly while in LOAD, so it qualifies acceptance
    assign accept = din_ready & din_valid;

    // state, counters and registered output decode
    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q   <= IDLE;
            word_q    <= '0;
            row_q     <= '0;
            pcnt_q    <= '0;
            din_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wl_out    <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            row_q     <= row_d;
            pcnt_q    <= pcnt_d;
            din_ready <= (state_d == LOAD);
            busy      <= (state_d == LOAD) ||
                         (state_d == PULSE) ||
                         (state_d == GAP);
            done      <= done_d;
            wl_out    <= (state_d == PULSE) ?
                         (WL_WIDTH'(1) << row_d) : '0;
        end
    end

    // each accepted word overwrites its LSB-first slice of the row
    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            bl_out <= '0;
        end else if (accept) begin
            for (int i = 0; i < BL_WIDTH; i++) begin
                if (WW'(i / DIN_WIDTH) == word_q)
                    bl_out[i] <= din_data[i % DIN_WIDTH];
            end
        end
    end

    // next-state and counter updates
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        row_d   = row_q;
        pcnt_d  = pcnt_q;
        done_d  = done;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    word_d  = '0;
                    row_d   = '0;
                    done_d  = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (word_q == WORD_LAST) begin
                        state_d = PULSE;
                        pcnt_d  = '0;
                    end else begin
                        word_d = word_q + WW'(1);
                    end
                end
            end
            PULSE: begin
                if (pcnt_q == PULSE_LAST)
                    state_d = GAP;
                else
                    pcnt_d = pcnt_q + PW'(1);
            end
            GAP: begin
                if (row_q == ROW_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                    row_d   = row_q + RW'(1);
                    word_d  = '0;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    word_d  = '0;
                    row_d   = '0;
                    done_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
